// File: rtl/pseudo_spi_sram_loader_pkg.sv
// Shared definitions for the pseudo-SPI SRAM loader: width parameters and
// FSM state encoding.
package pseudo_spi_sram_loader_pkg;

  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int MEMORY_ADDR_WIDTH = 9;
  localparam int RESERVED_DATA_LEN = 8;
  localparam int BIT_CNT_WIDTH     = $clog2(MEMORY_DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_ARM   = 3'd1,
    LDR_SHIFT = 3'd2,
    LDR_WRITE = 3'd3,
    LDR_DONE  = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/pseudo_spi_sram_loader_deser.sv
// Deserialiser for the pseudo-SPI receive path.
// Registers SCLK1/SCLK2/LAT once in the system clock and detects rising edges,
// shifts SPI_SI in LSB first on SCLK2 edges, counts bits (saturating at a full
// frame) and flags framing errors.
// Ports:
//   i_clk, i_rst_n      system clock, async active-low reset
//   i_sclk1/i_sclk2     two-phase serial clocks
//   i_lat               byte-complete strobe
//   i_spi_si            serial data, LSB first
//   i_shift_en          edges are acted upon only while high
//   i_clr_cnt           clear bit counter
//   i_clr_err           clear sticky framing error
//   o_byte              shift register value including any bit shifted this cycle
//   o_byte_vld          LAT edge with a complete frame
//   o_frm_err           sticky framing error
module pseudo_spi_sram_loader_deser
  import pseudo_spi_sram_loader_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_sclk1,
  input  logic                         i_sclk2,
  input  logic                         i_lat,
  input  logic                         i_spi_si,
  input  logic                         i_shift_en,
  input  logic                         i_clr_cnt,
  input  logic                         i_clr_err,
  output logic [MEMORY_DATA_WIDTH-1:0] o_byte,
  output logic                         o_byte_vld,
  output logic                         o_frm_err
);

  localparam logic [BIT_CNT_WIDTH-1:0] FULL_CNT = BIT_CNT_WIDTH'(MEMORY_DATA_WIDTH);

  logic                         r_sclk1_q, r_sclk1_qq;
  logic                         r_sclk2_q, r_sclk2_qq;
  logic                         r_lat_q, r_lat_qq;
  logic [MEMORY_DATA_WIDTH-1:0] r_sreg;
  logic [BIT_CNT_WIDTH-1:0]     r_bit_cnt;
  logic                         r_frm_err;

  logic                         w_sclk2_rise;
  logic                         w_lat_rise;
  logic                         w_unused_sclk1_rise;
  logic [MEMORY_DATA_WIDTH-1:0] w_sreg_nxt;
  logic [BIT_CNT_WIDTH-1:0]     w_cnt_nxt;
  logic                         w_overflow;
  logic                         w_short;

  // Phase-1 edges mark when the transmitter updates SPI_SI; the receiver has
  // nothing to do on them, sampling happens on phase 2.
  assign w_unused_sclk1_rise = r_sclk1_q & ~r_sclk1_qq;

  assign w_sclk2_rise = r_sclk2_q & ~r_sclk2_qq & i_shift_en;
  assign w_lat_rise   = r_lat_q & ~r_lat_qq & i_shift_en;

  assign w_sreg_nxt = w_sclk2_rise ? {i_spi_si, r_sreg[MEMORY_DATA_WIDTH-1:1]} : r_sreg;
  assign w_overflow = w_sclk2_rise && (r_bit_cnt == FULL_CNT);
  assign w_cnt_nxt  = (w_sclk2_rise && (r_bit_cnt != FULL_CNT)) ? r_bit_cnt + 1'b1 : r_bit_cnt;

  // LAT is judged on the count including a bit shifted in the same cycle.
  assign o_byte_vld = w_lat_rise & (w_cnt_nxt == FULL_CNT);
  assign w_short    = w_lat_rise & (w_cnt_nxt != FULL_CNT);
  assign o_byte     = w_sreg_nxt;
  assign o_frm_err  = r_frm_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk1_q  <= 1'b0;
      r_sclk1_qq <= 1'b0;
      r_sclk2_q  <= 1'b0;
      r_sclk2_qq <= 1'b0;
      r_lat_q    <= 1'b0;
      r_lat_qq   <= 1'b0;
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_frm_err  <= 1'b0;
    end else begin
      r_sclk1_q  <= i_sclk1;
      r_sclk1_qq <= r_sclk1_q;
      r_sclk2_q  <= i_sclk2;
      r_sclk2_qq <= r_sclk2_q;
      r_lat_q    <= i_lat;
      r_lat_qq   <= r_lat_q;
      r_sreg     <= w_sreg_nxt;

      if (i_clr_cnt || w_short) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= w_cnt_nxt;
      end

      if (i_clr_err) begin
        r_frm_err <= 1'b0;
      end else if (w_overflow || w_short) begin
        r_frm_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pseudo_spi_sram_loader.sv
// Receive side of the pseudo-SPI link: deserialises bytes and writes them into
// a 512x8 SRAM from i_addr_bgn downward.
// Ports:
//   i_clk, i_rst_n        system clock, async active-low reset
//   i_bgn                 level start; rising edge arms a transfer, low aborts
//   i_addr_bgn            address of first (highest) byte
//   i_data_len            byte count minus one
//   i_sclk1/i_sclk2/i_lat serial clocks and byte strobe
//   i_spi_si              serial data, LSB first
//   o_cen/o_wen           SRAM chip/write enable, active low
//   o_a/o_d               SRAM address / write data
//   o_rdy                 idle, ready for a new start
//   o_done                transfer complete, held until i_bgn falls
//   o_frm_err             sticky framing error
//
// state     | meaning
// LDR_IDLE  | waiting for a rising edge on i_bgn
// LDR_ARM   | load start address, byte count; clear framing error
// LDR_SHIFT | collecting serial bits until LAT
// LDR_WRITE | single-cycle SRAM write of the received byte
// LDR_DONE  | all bytes written, waiting for i_bgn to fall
module pseudo_spi_sram_loader
  import pseudo_spi_sram_loader_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_bgn,
  input  logic [MEMORY_ADDR_WIDTH-1:0] i_addr_bgn,
  input  logic [RESERVED_DATA_LEN-1:0] i_data_len,
  input  logic                         i_sclk1,
  input  logic                         i_sclk2,
  input  logic                         i_lat,
  input  logic                         i_spi_si,
  output logic                         o_cen,
  output logic                         o_wen,
  output logic [MEMORY_ADDR_WIDTH-1:0] o_a,
  output logic [MEMORY_DATA_WIDTH-1:0] o_d,
  output logic                         o_rdy,
  output logic                         o_done,
  output logic                         o_frm_err
);

  ldr_state_e                   r_state, w_state_nxt;
  logic                         r_bgn_q;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
  logic [RESERVED_DATA_LEN-1:0] r_bytes_left;
  logic                         r_cen, r_wen;
  logic [MEMORY_ADDR_WIDTH-1:0] r_a;
  logic [MEMORY_DATA_WIDTH-1:0] r_d;

  logic                         w_bgn_rise;
  logic                         w_shift_en;
  logic                         w_clr_cnt;
  logic                         w_clr_err;
  logic [MEMORY_DATA_WIDTH-1:0] w_byte;
  logic                         w_byte_vld;

  assign w_bgn_rise = i_bgn & ~r_bgn_q;

  pseudo_spi_sram_loader_deser u_deser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sclk1    (i_sclk1),
    .i_sclk2    (i_sclk2),
    .i_lat      (i_lat),
    .i_spi_si   (i_spi_si),
    .i_shift_en (w_shift_en),
    .i_clr_cnt  (w_clr_cnt),
    .i_clr_err  (w_clr_err),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld),
    .o_frm_err  (o_frm_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_clr_cnt   = 1'b0;
    w_clr_err   = 1'b0;
    case (r_state)
      LDR_IDLE: begin
        if (w_bgn_rise) w_state_nxt = LDR_ARM;
      end
      LDR_ARM: begin
        w_clr_cnt   = 1'b1;
        w_clr_err   = 1'b1;
        w_state_nxt = i_bgn ? LDR_SHIFT : LDR_IDLE;
      end
      LDR_SHIFT: begin
        w_shift_en = 1'b1;
        if (!i_bgn) begin
          w_state_nxt = LDR_IDLE;
        end else if (w_byte_vld) begin
          w_state_nxt = LDR_WRITE;
        end
      end
      LDR_WRITE: begin
        w_clr_cnt = 1'b1;
        if (!i_bgn) begin
          w_state_nxt = LDR_IDLE;
        end else if (r_bytes_left == '0) begin
          w_state_nxt = LDR_DONE;
        end else begin
          w_state_nxt = LDR_SHIFT;
        end
      end
      LDR_DONE: begin
        if (!i_bgn) w_state_nxt = LDR_IDLE;
      end
      default: w_state_nxt = LDR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= LDR_IDLE;
      r_bgn_q      <= 1'b0;
      r_addr       <= '0;
      r_bytes_left <= '0;
      r_cen        <= 1'b1;
      r_wen        <= 1'b1;
      r_a          <= '0;
      r_d          <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bgn_q <= i_bgn;

      if (r_state == LDR_ARM) begin
        r_addr       <= i_addr_bgn;
        r_bytes_left <= i_data_len;
      end else if (r_state == LDR_WRITE && i_bgn && r_bytes_left != '0) begin
        // Descending order; address 0 wraps naturally to the top of the SRAM.
        r_addr       <= r_addr - 1'b1;
        r_bytes_left <= r_bytes_left - 1'b1;
      end

      // SRAM strobes are registered from the next state so they line up
      // exactly with the WRITE cycle.
      r_cen <= (w_state_nxt != LDR_WRITE);
      r_wen <= (w_state_nxt != LDR_WRITE);
      if (w_state_nxt == LDR_WRITE) begin
        r_a <= r_addr;
        r_d <= w_byte;
      end
    end
  end

  assign o_cen  = r_cen;
  assign o_wen  = r_wen;
  assign o_a    = r_a;
  assign o_d    = r_d;
  assign o_rdy  = (r_state == LDR_IDLE);
  assign o_done = (r_state == LDR_DONE);

endmodule

// File: tb/tb_pseudo_spi_sram_loader.sv
module tb_pseudo_spi_sram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bgn = 1'b0;
  logic [8:0] addr_bgn = '0;
  logic [7:0] data_len = '0;
  logic       sclk1 = 1'b0, sclk2 = 1'b0, lat = 1'b0, si = 1'b0;
  logic       cen, wen, rdy, done, frm_err;
  logic [8:0] a;
  logic [7:0] d;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat_cyc = 0;

  logic [8:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  logic [8:0] ea[$];
  logic [7:0] ed[$];

  pseudo_spi_sram_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bgn      (bgn),
    .i_addr_bgn (addr_bgn),
    .i_data_len (data_len),
    .i_sclk1    (sclk1),
    .i_sclk2    (sclk2),
    .i_lat      (lat),
    .i_spi_si   (si),
    .o_cen      (cen),
    .o_wen      (wen),
    .o_a        (a),
    .o_d        (d),
    .o_rdy      (rdy),
    .o_done     (done),
    .o_frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture every SRAM write cycle seen on the pins.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cen === 1'b0 && wen === 1'b0) begin
      wa.push_back(a);
      wd.push_back(d);
      wc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int adr, input int len);
    addr_bgn = 9'(adr);
    data_len = 8'(len);
    bgn = 1'b1;
    step(3);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      si = b[i];
      sclk1 = 1'b1; step(1);
      sclk1 = 1'b0; sclk2 = 1'b1; step(2);
      sclk2 = 1'b0; step(2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits);
    send_bits(b, nbits);
    lat = 1'b1;
    lat_cyc = cyc;
    step(2);
    lat = 1'b0;
    step(2);
  endtask

  // Model: byte k of a transfer lands at (start - k) mod 512.
  task automatic expect_byte(input int start_adr, input int k, input logic [7:0] b);
    ea.push_back(9'(((start_adr - k) % 512 + 512) % 512));
    ed.push_back(b);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, wa.size(), ea.size());
    n = (wa.size() < ea.size()) ? wa.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_a%0d", tag, i), wa[i], ea[i]);
      check($sformatf("%s_d%0d", tag, i), wd[i], ed[i]);
    end
    wa.delete(); wd.delete(); wc.delete(); ea.delete(); ed.delete();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && done !== 1'b1; i++) step(1);
    check(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int adr, nb;

    // Reset values
    step(2);
    check("rst_rdy", rdy, 1);
    check("rst_done", done, 0);
    check("rst_cen", cen, 1);
    check("rst_wen", wen, 1);
    check("rst_a", a, 0);
    check("rst_d", d, 0);
    check("rst_frm", frm_err, 0);
    rst_n = 1'b1;
    step(2);

    // Single byte at the top address, latency from LAT pin to write
    start(9'h1FF, 0);
    send_frame(8'h5A, 8);
    wait_done("single_done");
    check("single_frm", frm_err, 0);
    check("single_lat", (wc.size() > 0) ? wc[0] - lat_cyc : -1, 2);
    expect_byte(9'h1FF, 0, 8'h5A);
    compare_writes("single");
    bgn = 1'b0; step(2);
    check("single_idle_rdy", rdy, 1);
    check("single_idle_done", done, 0);

    // Address wrap below zero
    start(1, 2);
    send_frame(8'h11, 8); expect_byte(1, 0, 8'h11);
    send_frame(8'h22, 8); expect_byte(1, 1, 8'h22);
    send_frame(8'h33, 8); expect_byte(1, 2, 8'h33);
    wait_done("wrap_done");
    compare_writes("wrap");
    bgn = 1'b0; step(2);

    // Random transfers
    for (int t = 0; t < 4; t++) begin
      adr = $urandom_range(0, 511);
      nb  = $urandom_range(1, 4);
      start(adr, nb - 1);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        send_frame(b, 8);
        expect_byte(adr, k, b);
      end
      wait_done($sformatf("rand%0d_done", t));
      check($sformatf("rand%0d_frm", t), frm_err, 0);
      compare_writes($sformatf("rand%0d", t));
      bgn = 1'b0; step(2);
    end

    // Short frame: error, no write, next full frame goes to the same address
    start(100, 1);
    send_frame(8'hFF, 5);
    check("short_frm", frm_err, 1);
    check("short_nowrite", wa.size(), 0);
    send_frame(8'h3C, 8); expect_byte(100, 0, 8'h3C);
    send_frame(8'h81, 8); expect_byte(100, 1, 8'h81);
    wait_done("short_done");
    check("short_frm_sticky", frm_err, 1);
    compare_writes("short");
    bgn = 1'b0; step(2);
    check("short_frm_idle", frm_err, 1);

    // Abort after 3 of 6 bytes, then restart from the start address
    start(50, 5);
    check("abort_frm_clr", frm_err, 0);
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      send_frame(b, 8);
      expect_byte(50, k, b);
    end
    bgn = 1'b0; step(3);
    check("abort_rdy", rdy, 1);
    check("abort_done", done, 0);
    compare_writes("abort");
    start(50, 5);
    send_frame(8'hAA, 8); expect_byte(50, 0, 8'hAA);
    compare_writes("restart");
    bgn = 1'b0; step(3);

    // Async reset landing in the WRITE cycle
    start(7, 0);
    send_bits(8'hC3, 8);
    lat = 1'b1;
    for (int i = 0; i < 6 && cen !== 1'b0; i++) step(1);
    check("rstw_reached", cen, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_cen", cen, 1);
    check("rstw_wen", wen, 1);
    check("rstw_rdy", rdy, 1);
    lat = 1'b0;
    bgn = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);
    check("rstw_nowrite", wa.size(), 0);
    check("rstw_idle", rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
